// File: rtl/dtl_arbiter_2to1.sv
// Two-initiator, one-target DTL arbiter.
// Round-robin arbitration at command level. The grant is held until the
// transaction's last read or write beat completes, so bursts from the two
// masters never interleave. All handshakes pass through combinationally.
module dtl_arbiter_2to1 #(
   parameter int INTERFACE_WIDTH       = 32,
   parameter int INTERFACE_ADDR_WIDTH  = 32,
   parameter int INTERFACE_BLOCK_WIDTH = 5,
   parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
   input  logic                             iClk,
   input  logic                             iReset,
   // master 0
   input  logic                             iM0_CommandValid,
   input  logic [INTERFACE_ADDR_WIDTH-1:0]  iM0_Address,
   input  logic                             iM0_CommandReadWrite,
   input  logic [INTERFACE_BLOCK_WIDTH-1:0] iM0_BlockSize,
   output logic                             oM0_CommandAccept,
   output logic                             oM0_ReadValid,
   output logic                             oM0_ReadLast,
   output logic [INTERFACE_WIDTH-1:0]       oM0_ReadData,
   input  logic                             iM0_ReadAccept,
   input  logic                             iM0_WriteValid,
   input  logic                             iM0_WriteLast,
   input  logic [INTERFACE_NUM_ENABLES-1:0] iM0_WriteEnable,
   input  logic [INTERFACE_WIDTH-1:0]       iM0_WriteData,
   output logic                             oM0_WriteAccept,
   // master 1
   input  logic                             iM1_CommandValid,
   input  logic [INTERFACE_ADDR_WIDTH-1:0]  iM1_Address,
   input  logic                             iM1_CommandReadWrite,
   input  logic [INTERFACE_BLOCK_WIDTH-1:0] iM1_BlockSize,
   output logic                             oM1_CommandAccept,
   output logic                             oM1_ReadValid,
   output logic                             oM1_ReadLast,
   output logic [INTERFACE_WIDTH-1:0]       oM1_ReadData,
   input  logic                             iM1_ReadAccept,
   input  logic                             iM1_WriteValid,
   input  logic                             iM1_WriteLast,
   input  logic [INTERFACE_NUM_ENABLES-1:0] iM1_WriteEnable,
   input  logic [INTERFACE_WIDTH-1:0]       iM1_WriteData,
   output logic                             oM1_WriteAccept,
   // slave
   output logic                             oS_CommandValid,
   output logic [INTERFACE_ADDR_WIDTH-1:0]  oS_Address,
   output logic                             oS_CommandReadWrite,
   output logic [INTERFACE_BLOCK_WIDTH-1:0] oS_BlockSize,
   input  logic                             iS_CommandAccept,
   input  logic                             iS_ReadValid,
   input  logic                             iS_ReadLast,
   input  logic [INTERFACE_WIDTH-1:0]       iS_ReadData,
   output logic                             oS_ReadAccept,
   output logic                             oS_WriteValid,
   output logic                             oS_WriteLast,
   output logic [INTERFACE_NUM_ENABLES-1:0] oS_WriteEnable,
   output logic [INTERFACE_WIDTH-1:0]       oS_WriteData,
   input  logic                             iS_WriteAccept,
   // status
   output logic                             oGrant,
   output logic                             oBusy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t state;
   logic   grant;        // master currently owning the slave
   logic   last_served;  // master that completed the most recent transaction

   // Signals of the granted master, selected by the grant register.
   logic                             g_cmd_valid;
   logic [INTERFACE_ADDR_WIDTH-1:0]  g_address;
   logic                             g_read_write;
   logic [INTERFACE_BLOCK_WIDTH-1:0] g_block_size;
   logic                             g_read_accept;
   logic                             g_write_valid;
   logic                             g_write_last;
   logic [INTERFACE_NUM_ENABLES-1:0] g_write_enable;
   logic [INTERFACE_WIDTH-1:0]       g_write_data;

   // Winner of an IDLE arbitration round.
   logic pick;

   // Select the granted master's request, command and write channel.
   always_comb begin
      g_cmd_valid    = grant ? iM1_CommandValid     : iM0_CommandValid;
      g_address      = grant ? iM1_Address          : iM0_Address;
      g_read_write   = grant ? iM1_CommandReadWrite : iM0_CommandReadWrite;
      g_block_size   = grant ? iM1_BlockSize        : iM0_BlockSize;
      g_read_accept  = grant ? iM1_ReadAccept       : iM0_ReadAccept;
      g_write_valid  = grant ? iM1_WriteValid       : iM0_WriteValid;
      g_write_last   = grant ? iM1_WriteLast        : iM0_WriteLast;
      g_write_enable = grant ? iM1_WriteEnable      : iM0_WriteEnable;
      g_write_data   = grant ? iM1_WriteData        : iM0_WriteData;
   end

   // Round-robin choice: a lone requester wins, a tie goes to whoever was not served last.
   always_comb begin
      if (iM0_CommandValid && iM1_CommandValid) begin
         pick = ~last_served;
      end else begin
         pick = iM1_CommandValid;
      end
   end

   // Transaction sequencer: arbitrate, forward the command, then hold until the last beat.
   always_ff @(posedge iClk) begin
      // NOTE: all state registers use non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (iReset) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_served <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (iM0_CommandValid || iM1_CommandValid) begin
                  grant <= pick;
                  state <= CMD;
               end
            end
            CMD: begin
               if (!g_cmd_valid) begin
                  // Command withdrawn before acceptance: abandon without
                  // counting it as served.
                  state <= IDLE;
               end else if (iS_CommandAccept) begin
                  state <= g_read_write ? READ : WRITE;
               end
            end
            READ: begin
               if (iS_ReadValid && g_read_accept && iS_ReadLast) begin
                  state       <= IDLE;
                  last_served <= grant;
               end
            end
            WRITE: begin
               if (g_write_valid && iS_WriteAccept && g_write_last) begin
                  state       <= IDLE;
                  last_served <= grant;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Route handshakes and data for the current phase; everything else is held at zero.
   always_comb begin
      // NOTE: every output gets a default before the case statement so that
      // no path leaves a signal unassigned, which would infer a latch.
      oM0_CommandAccept   = 1'b0;
      oM1_CommandAccept   = 1'b0;
      oM0_ReadValid       = 1'b0;
      oM1_ReadValid       = 1'b0;
      oM0_ReadLast        = 1'b0;
      oM1_ReadLast        = 1'b0;
      oM0_ReadData        = '0;
      oM1_ReadData        = '0;
      oM0_WriteAccept     = 1'b0;
      oM1_WriteAccept     = 1'b0;
      oS_CommandValid     = 1'b0;
      oS_Address          = '0;
      oS_CommandReadWrite = 1'b0;
      oS_BlockSize        = '0;
      oS_ReadAccept       = 1'b0;
      oS_WriteValid       = 1'b0;
      oS_WriteLast        = 1'b0;
      oS_WriteEnable      = '0;
      oS_WriteData        = '0;
      case (state)
         CMD: begin
            oS_CommandValid     = g_cmd_valid;
            oS_Address          = g_address;
            oS_CommandReadWrite = g_read_write;
            oS_BlockSize        = g_block_size;
            if (grant) oM1_CommandAccept = iS_CommandAccept;
            else       oM0_CommandAccept = iS_CommandAccept;
         end
         READ: begin
            oS_ReadAccept = g_read_accept;
            if (grant) begin
               oM1_ReadValid = iS_ReadValid;
               oM1_ReadLast  = iS_ReadLast;
               oM1_ReadData  = iS_ReadData;
            end else begin
               oM0_ReadValid = iS_ReadValid;
               oM0_ReadLast  = iS_ReadLast;
               oM0_ReadData  = iS_ReadData;
            end
         end
         WRITE: begin
            oS_WriteValid  = g_write_valid;
            oS_WriteLast   = g_write_last;
            oS_WriteEnable = g_write_enable;
            oS_WriteData   = g_write_data;
            if (grant) oM1_WriteAccept = iS_WriteAccept;
            else       oM0_WriteAccept = iS_WriteAccept;
         end
         default: ;
      endcase
   end

   assign oGrant = grant;
   assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_dtl_arbiter_2to1.sv
// Self-checking bench for dtl_arbiter_2to1: a table of whole transactions
// with expected grants, plus hand-written stall, abort and reset sequences.
module tb_dtl_arbiter_2to1;

   localparam int W  = 32;
   localparam int AW = 32;
   localparam int BW = 5;
   localparam int NE = W / 8;

   logic iClk = 1'b0;
   logic iReset;

   // per-master stimulus and responses, index = master number
   logic          cv     [2];
   logic [AW-1:0] addr   [2];
   logic          crw    [2];
   logic [BW-1:0] cbs    [2];
   logic          cacc   [2];
   logic          rvalid [2];
   logic          rlast  [2];
   logic [W-1:0]  rdata  [2];
   logic          racc   [2];
   logic          wv     [2];
   logic          wlast  [2];
   logic [NE-1:0] wen    [2];
   logic [W-1:0]  wdata  [2];
   logic          wacc   [2];

   // slave side
   logic          s_cv, s_crw, s_cacc;
   logic [AW-1:0] s_addr;
   logic [BW-1:0] s_bs;
   logic          s_rv, s_rlast, s_racc;
   logic [W-1:0]  s_rdata;
   logic          s_wv, s_wlast, s_wacc;
   logic [NE-1:0] s_wen;
   logic [W-1:0]  s_wdata;
   logic          grant_o, busy_o;

   int n_checks = 0;
   int n_errors = 0;

   // scoreboard queues: expectations pushed when stimulus is driven
   logic         grant_q [$];
   logic [W-1:0] rd_q    [$];
   logic [W-1:0] wr_q    [$];

   dtl_arbiter_2to1 #(
      .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(AW),
      .INTERFACE_BLOCK_WIDTH(BW), .INTERFACE_NUM_ENABLES(NE)
   ) dut (
      .iClk(iClk), .iReset(iReset),
      .iM0_CommandValid(cv[0]), .iM0_Address(addr[0]), .iM0_CommandReadWrite(crw[0]),
      .iM0_BlockSize(cbs[0]), .oM0_CommandAccept(cacc[0]),
      .oM0_ReadValid(rvalid[0]), .oM0_ReadLast(rlast[0]), .oM0_ReadData(rdata[0]),
      .iM0_ReadAccept(racc[0]), .iM0_WriteValid(wv[0]), .iM0_WriteLast(wlast[0]),
      .iM0_WriteEnable(wen[0]), .iM0_WriteData(wdata[0]), .oM0_WriteAccept(wacc[0]),
      .iM1_CommandValid(cv[1]), .iM1_Address(addr[1]), .iM1_CommandReadWrite(crw[1]),
      .iM1_BlockSize(cbs[1]), .oM1_CommandAccept(cacc[1]),
      .oM1_ReadValid(rvalid[1]), .oM1_ReadLast(rlast[1]), .oM1_ReadData(rdata[1]),
      .iM1_ReadAccept(racc[1]), .iM1_WriteValid(wv[1]), .iM1_WriteLast(wlast[1]),
      .iM1_WriteEnable(wen[1]), .iM1_WriteData(wdata[1]), .oM1_WriteAccept(wacc[1]),
      .oS_CommandValid(s_cv), .oS_Address(s_addr), .oS_CommandReadWrite(s_crw),
      .oS_BlockSize(s_bs), .iS_CommandAccept(s_cacc),
      .iS_ReadValid(s_rv), .iS_ReadLast(s_rlast), .iS_ReadData(s_rdata),
      .oS_ReadAccept(s_racc),
      .oS_WriteValid(s_wv), .oS_WriteLast(s_wlast), .oS_WriteEnable(s_wen),
      .oS_WriteData(s_wdata), .iS_WriteAccept(s_wacc),
      .oGrant(grant_o), .oBusy(busy_o)
   );

   always #5 iClk = ~iClk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int m = 0; m < 2; m++) begin
         cv[m] = 1'b0; addr[m] = '0; crw[m] = 1'b0; cbs[m] = '0;
         racc[m] = 1'b0; wv[m] = 1'b0; wlast[m] = 1'b0; wen[m] = '0; wdata[m] = '0;
      end
      s_cacc = 1'b0; s_rv = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_wacc = 1'b0;
   endtask

   task automatic do_reset();
      iReset = 1'b1;
      clear_inputs();
      tick();
      tick();
      check("rst_busy", busy_o, 0);
      check("rst_grant", grant_o, 0);
      check("rst_s_cv", s_cv, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_cacc", {cacc[1], cacc[0]}, 0);
      check("rst_wacc", {wacc[1], wacc[0]}, 0);
      check("rst_rvalid", {rvalid[1], rvalid[0]}, 0);
      iReset = 1'b0;
   endtask

   // One full transaction starting in an IDLE cycle. 'late' raises the other
   // master's request during beat 1. Ends in the following IDLE cycle.
   task automatic run_txn(input logic [1:0] mask, input logic rw, input logic [BW-1:0] bs,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic late, input logic exp_g, input string tag);
      int g, ng;
      logic [W-1:0] d;
      cv[0] = mask[0]; cv[1] = mask[1];
      addr[0] = a0; addr[1] = a1;
      crw[0] = rw; crw[1] = rw;
      cbs[0] = bs; cbs[1] = bs;
      grant_q.push_back(exp_g);
      #1;
      check({tag, "_idle_busy"}, busy_o, 0);
      check({tag, "_idle_s_cv"}, s_cv, 0);
      tick();
      s_cacc = 1'b1;
      #1;
      if (grant_q.size() == 0) begin
         check({tag, "_grant_q_empty"}, 1, 0);
         g = exp_g;
      end else begin
         g = int'(grant_q.pop_front());
      end
      ng = 1 - g;
      check({tag, "_grant"}, grant_o, g);
      check({tag, "_cmd_busy"}, busy_o, 1);
      check({tag, "_s_cv"}, s_cv, 1);
      check({tag, "_s_addr"}, s_addr, (g == 1) ? a1 : a0);
      check({tag, "_s_rw"}, s_crw, rw);
      check({tag, "_s_bs"}, s_bs, bs);
      check({tag, "_cacc_g"}, cacc[g], 1);
      check({tag, "_cacc_ng"}, cacc[ng], 0);
      tick();
      s_cacc = 1'b0;
      cv[g] = 1'b0;
      for (int i = 0; i <= int'(bs); i++) begin
         if (late && i == 1) cv[ng] = 1'b1;
         if (rw) begin
            d = 32'hA000_0000 | (g << 16) | i;
            s_rv = 1'b1; s_rdata = d; s_rlast = (i == int'(bs));
            racc[0] = 1'b1; racc[1] = 1'b1;
            rd_q.push_back(d);
            #1;
            check({tag, "_rvalid_g"}, rvalid[g], 1);
            check({tag, "_rdata_g"}, rdata[g], rd_q.pop_front());
            check({tag, "_rlast_g"}, rlast[g], (i == int'(bs)));
            check({tag, "_rvalid_ng"}, rvalid[ng], 0);
            check({tag, "_rdata_ng"}, rdata[ng], 0);
            check({tag, "_s_racc"}, s_racc, 1);
         end else begin
            d = 32'hB000_0000 | (g << 16) | i;
            wv[g] = 1'b1; wdata[g] = d; wen[g] = NE'(i + 1); wlast[g] = (i == int'(bs));
            wv[ng] = 1'b1; wdata[ng] = 32'hDEAD_0000 | i; wen[ng] = '1; wlast[ng] = 1'b1;
            s_wacc = 1'b1;
            wr_q.push_back(d);
            #1;
            check({tag, "_s_wv"}, s_wv, 1);
            if (s_wv && s_wacc && wr_q.size() != 0) check({tag, "_s_wdata"}, s_wdata, wr_q.pop_front());
            check({tag, "_s_wen"}, s_wen, NE'(i + 1));
            check({tag, "_s_wlast"}, s_wlast, (i == int'(bs)));
            check({tag, "_wacc_g"}, wacc[g], 1);
            check({tag, "_wacc_ng"}, wacc[ng], 0);
         end
         tick();
      end
      s_rv = 1'b0; s_rlast = 1'b0; s_wacc = 1'b0;
      for (int m = 0; m < 2; m++) begin
         racc[m] = 1'b0; wv[m] = 1'b0; wlast[m] = 1'b0;
      end
      #1;
      check({tag, "_done_busy"}, busy_o, 0);
   endtask

   typedef struct {
      logic [1:0]    mask;
      logic          rw;
      logic [BW-1:0] bs;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          late;
      logic          exp_g;
   } vec_t;

   vec_t vecs [8];

   initial begin
      // grant expectations follow round-robin history starting from reset
      vecs[0] = '{mask: 2'b11, rw: 1'b0, bs: 5'd3, a0: 32'h200, a1: 32'h300, late: 1'b0, exp_g: 1'b0};
      vecs[1] = '{mask: 2'b10, rw: 1'b0, bs: 5'd3, a0: 32'h200, a1: 32'h300, late: 1'b0, exp_g: 1'b1};
      vecs[2] = '{mask: 2'b10, rw: 1'b1, bs: 5'd2, a0: 32'h500, a1: 32'h600, late: 1'b1, exp_g: 1'b1};
      vecs[3] = '{mask: 2'b01, rw: 1'b1, bs: 5'd0, a0: 32'h700, a1: 32'h000, late: 1'b0, exp_g: 1'b0};
      vecs[4] = '{mask: 2'b11, rw: 1'b1, bs: 5'd1, a0: 32'h810, a1: 32'h820, late: 1'b0, exp_g: 1'b1};
      vecs[5] = '{mask: 2'b11, rw: 1'b0, bs: 5'd0, a0: 32'h910, a1: 32'h920, late: 1'b0, exp_g: 1'b0};
      vecs[6] = '{mask: 2'b01, rw: 1'b0, bs: 5'd2, a0: 32'hA10, a1: 32'hA20, late: 1'b0, exp_g: 1'b0};
      vecs[7] = '{mask: 2'b11, rw: 1'b1, bs: 5'd0, a0: 32'hB10, a1: 32'hB20, late: 1'b0, exp_g: 1'b1};

      iReset = 1'b1;
      clear_inputs();
      do_reset();

      for (int v = 0; v < 8; v++) begin
         run_txn(vecs[v].mask, vecs[v].rw, vecs[v].bs, vecs[v].a0, vecs[v].a1,
                 vecs[v].late, vecs[v].exp_g, $sformatf("vec%0d", v));
      end

      // lone M0 single-beat read right after reset
      do_reset();
      run_txn(2'b01, 1'b1, 5'd0, 32'h100, 32'h0, 1'b0, 1'b0, "m0_read");

      // M1 wins a tie, then withdraws its command: history must be unchanged
      cv[0] = 1'b1; cv[1] = 1'b1; crw[0] = 1'b1; crw[1] = 1'b1;
      tick();
      check("abort_grant", grant_o, 1);
      check("abort_busy", busy_o, 1);
      cv[0] = 1'b0; cv[1] = 1'b0;
      tick();
      check("abort_idle", busy_o, 0);
      run_txn(2'b11, 1'b1, 5'd0, 32'hC10, 32'hC20, 1'b0, 1'b1, "after_abort");

      // stalled read: 5 cycles without valid, then last beat held by accept
      cv[0] = 1'b1; crw[0] = 1'b1; cbs[0] = 5'd1; addr[0] = 32'h400;
      tick();
      s_cacc = 1'b1;
      tick();
      s_cacc = 1'b0; cv[0] = 1'b0; racc[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_nv_busy", busy_o, 1);
         check("stall_nv_grant", grant_o, 0);
         check("stall_nv_rvalid", rvalid[0], 0);
         tick();
      end
      s_rv = 1'b1; s_rlast = 1'b0; s_rdata = 32'h1234_5678;
      #1;
      check("stall_b0_rdata", rdata[0], 32'h1234_5678);
      tick();
      s_rlast = 1'b1; s_rdata = 32'h8765_4321; racc[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_hold_s_racc", s_racc, 0);
         check("stall_hold_busy", busy_o, 1);
         check("stall_hold_rlast", rlast[0], 1);
         tick();
      end
      racc[0] = 1'b1;
      #1;
      check("stall_final_s_racc", s_racc, 1);
      tick();
      clear_inputs();
      #1;
      check("stall_done_busy", busy_o, 0);

      // reset during beat 2 of a 4-beat write from M1
      cv[1] = 1'b1; crw[1] = 1'b0; cbs[1] = 5'd3; addr[1] = 32'hE00;
      tick();
      check("rstmid_grant", grant_o, 1);
      s_cacc = 1'b1;
      tick();
      s_cacc = 1'b0; cv[1] = 1'b0;
      wv[1] = 1'b1; wlast[1] = 1'b0; wdata[1] = 32'h5555_0000; s_wacc = 1'b1;
      tick();
      tick();
      iReset = 1'b1;
      tick();
      check("rstmid_busy", busy_o, 0);
      check("rstmid_grant0", grant_o, 0);
      check("rstmid_wacc", {wacc[1], wacc[0]}, 0);
      check("rstmid_s_wv", s_wv, 0);
      iReset = 1'b0;
      clear_inputs();
      run_txn(2'b10, 1'b1, 5'd1, 32'h0, 32'hF00, 1'b0, 1'b1, "post_rst_m1");

      // continuous requests from both masters alternate strictly
      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_txn(2'b11, logic'(i % 2), 5'd1, 32'h1000 + i, 32'h2000 + i, 1'b0,
                 logic'(i % 2), $sformatf("alt%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dtl_arbiter_2to1.md
Name: dtl_arbiter_2to1

Overview:
- Two-initiator, one-target arbiter for the DTL bus.
- Two DTL masters (M0, M1) share a single DTL slave interface, for example one memory-mapped CGRA memory port.
- Command-level round-robin arbitration. The grant is held for the whole block transaction, so read and write bursts are never interleaved between masters.
- Sits between the masters and the slave interface; all DTL handshake semantics pass through unchanged.

Parameters:
- INTERFACE_WIDTH, 32: data width.
- INTERFACE_ADDR_WIDTH, 32: address width.
- INTERFACE_BLOCK_WIDTH, 5: BlockSize width; burst length = BlockSize+1.
- INTERFACE_NUM_ENABLES, INTERFACE_WIDTH/8: byte enables.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iMx_CommandValid, iMx_Address, iMx_CommandReadWrite, iMx_BlockSize  in  1/ADDR/1/BLOCK  master x command (x = 0, 1; one set per master).
- oMx_CommandAccept  out  1  command accept to master x.
- oMx_ReadValid, oMx_ReadLast  out  1/1  read channel to master x.
- oMx_ReadData  out  WIDTH  read data to master x.
- iMx_ReadAccept  in  1  read accept from master x.
- iMx_WriteValid, iMx_WriteLast  in  1/1  write channel from master x.
- iMx_WriteEnable  in  NUM_ENABLES  write byte enables from master x.
- iMx_WriteData  in  WIDTH  write data from master x.
- oMx_WriteAccept  out  1  write accept to master x.
- oS_CommandValid, oS_Address, oS_CommandReadWrite, oS_BlockSize  out  1/ADDR/1/BLOCK  command to slave.
- iS_CommandAccept  in  1  command accept from slave.
- iS_ReadValid, iS_ReadLast  in  1/1  read channel from slave.
- iS_ReadData  in  WIDTH  read data from slave.
- oS_ReadAccept  out  1  read accept to slave.
- oS_WriteValid, oS_WriteLast, oS_WriteEnable, oS_WriteData  out  1/1/NUM_ENABLES/WIDTH  write channel to slave.
- iS_WriteAccept  in  1  write accept from slave.
- oGrant  out  1  index of the granted master; valid when oBusy=1.
- oBusy  out  1  arbiter is not in IDLE.

Behaviour:
- State register: IDLE, CMD, READ, WRITE (2 bits).
- Registers: rGrant (granted master), rLast (last master served).
- Reset values:
  - state=IDLE, rGrant=0, rLast=1, so M0 wins the first tie.
  - All valid, accept and last outputs 0; all data, address and size outputs 0; oBusy=0; oGrant=0.
- IDLE:
  - All oMx_* accept/valid outputs are 0, and oS_CommandValid=0.
  - If exactly one iMx_CommandValid is high, grant that master.
  - If both are high, grant master (1-rLast).
  - On any grant: register rGrant, go to CMD. This gives 1 cycle of arbitration latency.
- CMD:
  - oS_Command* = granted master's command inputs (combinational mux).
  - oMg_CommandAccept = iS_CommandAccept. The non-granted master's CommandAccept is 0.
  - On iMg_CommandValid & iS_CommandAccept: go to READ if ReadWrite=1, otherwise go to WRITE.
  - If the granted master drops CommandValid before acceptance (protocol violation), return to IDLE without updating rLast.
- READ:
  - iS_ReadValid, iS_ReadLast and iS_ReadData are routed to the granted master.
  - oS_ReadAccept = iMg_ReadAccept.
  - Completion on iS_ReadValid & iMg_ReadAccept & iS_ReadLast: go to IDLE and set rLast=rGrant.
- WRITE:
  - iMg_WriteValid, WriteLast, WriteEnable and WriteData are routed to the slave.
  - oMg_WriteAccept = iS_WriteAccept.
  - Completion on iMg_WriteValid & iS_WriteAccept & iMg_WriteLast: go to IDLE and set rLast=rGrant.
- Non-granted master:
  - All its outputs stay 0: CommandAccept, ReadValid, ReadLast, ReadData=0, WriteAccept.
  - Its requests are held pending, never dropped.
- Outside CMD / READ / WRITE respectively, the slave-side valid/accept outputs are 0. The slave data buses may carry the granted master's values (don't care).
- No command pipelining: a new arbitration starts only after completion. Turnaround is IDLE to CMD, so a back-to-back transaction has a minimum 1-cycle bubble.
- Fairness:
  - With both masters continuously requesting, grants strictly alternate M0, M1, M0, ...
  - A lone requester is granted every transaction.
- Beat counting is not done here. Completion relies solely on ReadLast/WriteLast.
- Reset mid-transaction: returns to IDLE immediately on the next edge, with all outputs at reset values. The slave shares iReset, so no partial-burst recovery is attempted.
- Simultaneous completion and a new request from either master are resolved in the following IDLE cycle using the updated rLast.

Test Plan:
- Reset, then M0 alone issues read Address=0x100, BlockSize=0 → oGrant=0. Slave sees Address 0x100 in CMD the cycle after request. M0 gets 1 beat with ReadLast=1. oBusy returns to 0 after accept.
- Both masters request writes in the same cycle after reset, BlockSize=3 each → M0 served first with 4 beats, then M1 with 4 beats. oM1_WriteAccept=0 throughout M0's burst. Slave never sees M1 data during M0's burst.
- M1 read with BlockSize=2 while M0 requests mid-burst → M1 completes 3 beats uninterrupted. M0 is granted in the cycle after M1's last accepted beat plus 1.
- Slave stalls: iS_ReadValid low for 5 cycles, then iMg_ReadAccept low for 3 cycles on the last beat → grant and state are held. Completion occurs only on the cycle where valid&accept&last are all high.
- Continuous requests from both masters for 6 transactions → grant sequence is exactly 0, 1, 0, 1, 0, 1.
- iReset asserted during beat 2 of a 4-beat write → next cycle: state IDLE, all accepts 0, oBusy=0, oGrant=0. The next request from M1 alone is granted normally.
